// File: rtl/spi_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI transmit controller.
// Optional watchdog on the completion wait is compiled in with SPI_ARB_TIMEOUT_EN.
module spi_tx_arbiter #(
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Req0_DV,
    input  logic                   i_Req1_DV,
    input  logic [DATA_LENGTH-1:0] i_Req0_Word,
    input  logic [DATA_LENGTH-1:0] i_Req1_Word,
    output logic                   o_Req0_Ack,
    output logic                   o_Req1_Ack,
    output logic                   o_Req0_Done,
    output logic                   o_Req1_Done,
    output logic [DATA_LENGTH-1:0] o_TX_Word,
    output logic                   o_TX_DV,
    input  logic                   i_TX_Ready,
    output logic                   o_Core_Select,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic                   o_Timeout,
`endif
    output logic                   o_Busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e                 state_q, state_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [DATA_LENGTH-1:0] word_q, word_d;
    logic                   sel_q, sel_d;
    logic                   ack0_q, ack0_d, ack1_q, ack1_d;
    logic                   done0_q, done0_d, done1_q, done1_d;
    logic                   tx_dv_q, tx_dv_d;
    logic                   busy_q, busy_d;
    logic                   grant1;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]            cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= StIdle;
            first_q   <= 1'b0;
            last_q    <= 1'b1;  // requester 0 wins the first contention
            word_q    <= '0;
            sel_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            tx_dv_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            last_q    <= last_d;
            word_q    <= word_d;
            sel_q     <= sel_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            tx_dv_q   <= tx_dv_d;
            busy_q    <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        last_d    = last_q;
        word_d    = word_q;
        sel_d     = sel_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        tx_dv_d   = 1'b0;
        // Requester 1 wins when alone, or on contention when 0 was served last.
        grant1    = i_Req1_DV && (!i_Req0_DV || !last_q);
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_TX_Ready && (i_Req0_DV || i_Req1_DV)) begin
                    sel_d   = grant1;
                    last_d  = grant1;
                    word_d  = grant1 ? i_Req1_Word : i_Req0_Word;
                    ack0_d  = !grant1;
                    ack1_d  = grant1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tx_dv_d = 1'b1;
                first_d = 1'b1;
                state_d = StWaitDone;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWaitDone: begin
                // Ready is stale during the cycle DV is on the wire; skip it.
                if (!first_q && i_TX_Ready) begin
                    done0_d = !sel_q;
                    done1_d = sel_q;
                    state_d = StIdle;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign o_Req0_Ack    = ack0_q;
    assign o_Req1_Ack    = ack1_q;
    assign o_Req0_Done   = done0_q;
    assign o_Req1_Done   = done1_q;
    assign o_TX_Word     = word_q;
    assign o_TX_DV       = tx_dv_q;
    assign o_Core_Select = sel_q;
    assign o_Busy        = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign o_Timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter; the watchdog case runs only with SPI_ARB_TIMEOUT_EN.
module tb_spi_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_dv, req1_dv;
    logic [31:0] req0_word, req1_word;
    logic        ack0, ack1, done0, done1;
    logic [31:0] tx_word;
    logic        tx_dv, tx_ready, core_sel, busy;
`ifdef SPI_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_tx_arbiter #(
        .DATA_LENGTH   (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Req0_DV    (req0_dv),
        .i_Req1_DV    (req1_dv),
        .i_Req0_Word  (req0_word),
        .i_Req1_Word  (req1_word),
        .o_Req0_Ack   (ack0),
        .o_Req1_Ack   (ack1),
        .o_Req0_Done  (done0),
        .o_Req1_Done  (done1),
        .o_TX_Word    (tx_word),
        .o_TX_DV      (tx_dv),
        .i_TX_Ready   (tx_ready),
        .o_Core_Select(core_sel),
`ifdef SPI_ARB_TIMEOUT_EN
        .o_Timeout    (timeout),
`endif
        .o_Busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req0_dv   = 1'b0;
        req1_dv   = 1'b0;
        req0_word = '0;
        req1_word = '0;
        tx_ready  = 1'b0;
        do_reset();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_txdv", {31'd0, tx_dv}, 32'd0);
        check("rst_word", tx_word, 32'd0);
        check("rst_sel", {31'd0, core_sel}, 32'd0);
        check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("rst_dones", {30'd0, done1, done0}, 32'd0);

        // Single request from requester 0
        req0_dv   = 1'b1;
        req0_word = 32'hA5A5_0001;
        tx_ready  = 1'b1;
        tick();
        check("single_ack0", {30'd0, ack1, ack0}, 32'd1);
        check("single_sel", {31'd0, core_sel}, 32'd0);
        check("single_busy", {31'd0, busy}, 32'd1);
        check("single_txdv_early", {31'd0, tx_dv}, 32'd0);
        req0_dv = 1'b0;
        tick();
        check("single_txdv", {31'd0, tx_dv}, 32'd1);
        check("single_word", tx_word, 32'hA5A5_0001);
        check("single_ack_clear", {30'd0, ack1, ack0}, 32'd0);
        tx_ready = 1'b0;
        tick();
        check("single_txdv_pulse", {31'd0, tx_dv}, 32'd0);
        tick();
        check("single_wait_nodone", {30'd0, done1, done0}, 32'd0);
        check("single_wait_busy", {31'd0, busy}, 32'd1);
        check("single_wait_word", tx_word, 32'hA5A5_0001);
        tx_ready = 1'b1;
        tick();
        check("single_done0", {30'd0, done1, done0}, 32'd1);
        check("single_idle", {31'd0, busy}, 32'd0);
        tick();
        check("single_done_pulse", {30'd0, done1, done0}, 32'd0);

        // Contention from reset: expect 0,1,0,1
        req0_dv   = 1'b1;
        req1_dv   = 1'b1;
        req0_word = 32'h1111_1111;
        req1_word = 32'h2222_2222;
        tx_ready  = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic n;
            n = i[0];
            tick();
            check("cont_ack", {30'd0, ack1, ack0}, n ? 32'd2 : 32'd1);
            check("cont_sel", {31'd0, core_sel}, {31'd0, n});
            tick();
            check("cont_txdv", {31'd0, tx_dv}, 32'd1);
            check("cont_word", tx_word, n ? 32'h2222_2222 : 32'h1111_1111);
            tick();
            check("cont_nodone", {30'd0, done1, done0}, 32'd0);
            tick();
            check("cont_done", {30'd0, done1, done0}, n ? 32'd2 : 32'd1);
        end
        req0_dv = 1'b0;
        req1_dv = 1'b0;
        tick();

        // Back-pressure, then ready held high through issue (glitch immunity)
        do_reset();
        tx_ready  = 1'b0;
        req1_dv   = 1'b1;
        req1_word = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_noack", {30'd0, ack1, ack0}, 32'd0);
            check("bp_notxdv", {31'd0, tx_dv}, 32'd0);
        end
        tx_ready = 1'b1;
        tick();
        check("bp_ack1", {30'd0, ack1, ack0}, 32'd2);
        check("bp_sel1", {31'd0, core_sel}, 32'd1);
        req1_dv = 1'b0;
        tick();
        check("glitch_txdv", {31'd0, tx_dv}, 32'd1);
        check("glitch_nodone_dv", {30'd0, done1, done0}, 32'd0);
        tick();
        check("glitch_nodone_first", {30'd0, done1, done0}, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        tick();
        check("glitch_done1", {30'd0, done1, done0}, 32'd2);
        tick();

        // Reset mid-WAIT_DONE after serving requester 0
        req0_dv   = 1'b1;
        req0_word = 32'h0000_00C3;
        tick();
        check("mid_ack0", {30'd0, ack1, ack0}, 32'd1);
        req0_dv = 1'b0;
        tick();
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_txdv", {31'd0, tx_dv}, 32'd0);
        check("mid_nodone", {30'd0, done1, done0}, 32'd0);
        check("mid_word", tx_word, 32'd0);
        rst       = 1'b0;
        tx_ready  = 1'b1;
        req0_dv   = 1'b1;
        req1_dv   = 1'b1;
        req0_word = 32'h1111_1111;
        req1_word = 32'h2222_2222;
        tick();
        check("mid_regrant0", {30'd0, ack1, ack0}, 32'd1);
        check("mid_regrant_sel", {31'd0, core_sel}, 32'd0);
        req0_dv = 1'b0;
        req1_dv = 1'b0;
        tick();
        tick();
        tick();
        check("mid_done0", {30'd0, done1, done0}, 32'd1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: ready never returns
        do_reset();
        tx_ready  = 1'b1;
        req0_dv   = 1'b1;
        req0_word = 32'h0BAD_0BAD;
        tick();
        req0_dv = 1'b0;
        tick();
        check("to_txdv", {31'd0, tx_dv}, 32'd1);
        tx_ready = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_early", {31'd0, timeout}, 32'd0);
            check("to_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        check("to_pulse", {31'd0, timeout}, 32'd1);
        check("to_nodone", {30'd0, done1, done0}, 32'd0);
        tick();
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_clear", {31'd0, timeout}, 32'd0);
        check("to_nodone_after", {30'd0, done1, done0}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 SHALL provide parameter DATA_LENGTH, default 32, word width of every data port.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1024, watchdog limit in i_Clk cycles; legal range 2..65535.
REQ-003 SHALL provide i_Clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL provide i_Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide i_Req0_DV / i_Req1_DV  input  1 each  requester N has a word pending; held high until acknowledged.
REQ-006 SHALL provide i_Req0_Word / i_Req1_Word  input  DATA_LENGTH each  word from requester N.
REQ-007 SHALL provide o_Req0_Ack / o_Req1_Ack  output  1 each  one-cycle pulse: word from requester N captured.
REQ-008 SHALL provide o_Req0_Done / o_Req1_Done  output  1 each  one-cycle pulse: word from requester N fully shifted out.
REQ-009 SHALL provide o_TX_Word  output  DATA_LENGTH  word to the SPI chip-select controller.
REQ-010 SHALL provide o_TX_DV  output  1  one-cycle start pulse to the SPI controller.
REQ-011 SHALL provide i_TX_Ready  input  1  SPI controller idle and able to accept a word.
REQ-012 SHALL provide o_Core_Select  output  1  index of the requester currently owning the SPI link.
REQ-013 SHALL provide o_Busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_DONE, with all outputs registered.
REQ-015 In IDLE with i_TX_Ready=1 and at least one i_ReqN_DV=1, SHALL grant one requester, latch its word into o_TX_Word, pulse o_ReqN_Ack for that cycle edge, set o_Core_Select=N, and move to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; with one requesting, grant it regardless of history.
REQ-017 In ISSUE, SHALL assert o_TX_DV for exactly one cycle, then move to WAIT_DONE.
REQ-018 SHALL ignore i_TX_Ready during the ISSUE cycle and the first WAIT_DONE cycle (controller ready drops combinationally with DV).
REQ-019 In WAIT_DONE, from the second cycle onward, i_TX_Ready=1 SHALL pulse o_ReqN_Done for the granted requester and return to IDLE.
REQ-020 Latency: request seen in IDLE -> o_TX_DV high exactly 2 cycles later.
REQ-021 o_TX_Word and o_Core_Select SHALL remain stable from grant until return to IDLE.
REQ-022 A new grant SHALL NOT occur in the cycle o_ReqN_Done pulses; earliest next o_TX_DV is 2 cycles after Done.
REQ-023 Requests with i_TX_Ready=0 in IDLE SHALL wait without any Ack.
REQ-024 Requester dropping DV before Ack SHALL be treated as withdrawn; no side effects.

Reset
REQ-025 On i_Rst=1 at a clock edge: state IDLE; o_TX_DV, all Ack, Done, o_Busy = 0; o_TX_Word = 0; o_Core_Select = 0; round-robin pointer set so requester 0 wins the first contention.
REQ-026 Reset mid-transfer SHALL abort immediately with no Done pulse; o_TX_DV SHALL be 0 the cycle after reset asserts.

Configuration
REQ-027 Macro SPI_ARB_TIMEOUT_EN SHALL compile in a watchdog counter and output o_Timeout (1 bit).
REQ-028 With SPI_ARB_TIMEOUT_EN: counter clears on entering WAIT_DONE; if TIMEOUT_CYCLES cycles elapse without completion, pulse o_Timeout one cycle, no Done pulse, return to IDLE; counter and o_Timeout reset to 0.
REQ-029 Without SPI_ARB_TIMEOUT_EN: no counter, no o_Timeout port; WAIT_DONE waits indefinitely.

Verification
REQ-030 Single request: Req0 DV with word 0xA5A5_0001, TX_Ready=1 -> Ack0 next edge, TX_DV 2 cycles after request with TX_Word=0xA5A5_0001, Core_Select=0, Done0 after TX_Ready returns.
REQ-031 Contention: Req0 and Req1 both held from reset with 0x11111111/0x22222222 -> grant order 0,1,0,1; Core_Select toggles accordingly.
REQ-032 Back-pressure: TX_Ready=0 for 20 cycles with Req1 pending -> no Ack, TX_DV stays 0; TX_Ready rises -> Ack1 next edge.
REQ-033 Ready glitch: TX_Ready held 1 continuously during ISSUE and first WAIT_DONE cycle -> no Done in those cycles.
REQ-034 Reset mid-WAIT_DONE: assert i_Rst for 1 cycle -> Busy=0, no Done, next contention grants Req0 first.
REQ-035 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: TX_Ready held 0 after DV -> o_Timeout pulses 16 cycles after WAIT_DONE entry, Busy=0 next cycle, no Done.
